// File: rtl/reg_arbiter_if.sv
// Register-file access bus shared by the two requesters and the register file.
// slave = arbiter side, master = requester/register-file side.
interface reg_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int REGN_W = 4
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic              lock0;
    logic              lock1;
    logic [REGN_W-1:0] num0;
    logic [REGN_W-1:0] num1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              ack0;
    logic              ack1;
    logic [DATA_W-1:0] rdata;
    logic              LoadReg;
    logic              DumpReg;
    logic [REGN_W-1:0] RegNumber;
    logic [DATA_W-1:0] RegWData;
    logic [DATA_W-1:0] RegRData;

    modport slave (
        input  req0, req1, we0, we1, lock0, lock1,
        input  num0, num1, wdata0, wdata1, RegRData,
        output gnt0, gnt1, ack0, ack1, rdata,
        output LoadReg, DumpReg, RegNumber, RegWData
    );

    modport master (
        output req0, req1, we0, we1, lock0, lock1,
        output num0, num1, wdata0, wdata1, RegRData,
        input  gnt0, gnt1, ack0, ack1, rdata,
        input  LoadReg, DumpReg, RegNumber, RegWData
    );
endinterface

// File: rtl/reg_arbiter.sv
// Two-port register-file arbiter (IDLE/ACCESS/RESP) with lock and deadlock guard.
// Define ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority (port 0).
module reg_arbiter #(
    parameter int DATA_W = 8,
    parameter int REGN_W = 4
) (
    input  logic        clk,
    input  logic        reset,
    reg_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state;
    state_t            state_nx;
    logic              owner;
    logic              h_we;
    logic              h_lock;
    logic [REGN_W-1:0] h_num;
    logic [DATA_W-1:0] h_wdata;
    logic [3:0]        lock_cnt;

    logic              guard;
    logic              own_req;
    logic              locked;
    logic              grant;
    logic              win;
    logic              win_lock;
`ifdef ARB_ROUND_ROBIN_EN
    logic              rr_ptr;
`endif

    logic              gnt0;
    logic              gnt1;
    logic              ack0;
    logic              ack1;
    logic [DATA_W-1:0] rdata;
    logic              load_reg;
    logic              dump_reg;
    logic [REGN_W-1:0] reg_num;
    logic [DATA_W-1:0] reg_wdata;

    always_comb begin
        guard   = (lock_cnt == 4'hF);
        own_req = owner ? bus.req1 : bus.req0;
        locked  = h_lock && own_req && !guard;
        grant   = 1'b0;
        win     = 1'b0;
        if (state == IDLE) begin
            if (locked) begin
                grant = 1'b1;
                win   = owner;
            end else if (bus.req0 && bus.req1) begin
                grant = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                win   = rr_ptr;
`else
                win   = 1'b0;
`endif
            end else if (bus.req0 || bus.req1) begin
                grant = 1'b1;
                win   = bus.req1;
            end
        end
        win_lock = win ? bus.lock1 : bus.lock0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            owner    <= 1'b0;
            h_we     <= 1'b0;
            h_lock   <= 1'b0;
            h_num    <= '0;
            h_wdata  <= '0;
            lock_cnt <= 4'd0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr   <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            if (grant) begin
                owner   <= win;
                h_we    <= win ? bus.we1 : bus.we0;
                h_num   <= win ? bus.num1 : bus.num0;
                h_wdata <= win ? bus.wdata1 : bus.wdata0;
                h_lock  <= win_lock;
                // count a run of locked grants; a guard arbitration restarts it
                if (guard || !win_lock)
                    lock_cnt <= 4'd0;
                else if (locked)
                    lock_cnt <= lock_cnt + 4'd1;
                else
                    lock_cnt <= 4'd1;
`ifdef ARB_ROUND_ROBIN_EN
                rr_ptr  <= ~win;
`endif
            end
        end
    end

    always_comb begin
        state_nx  = IDLE;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        ack0      = 1'b0;
        ack1      = 1'b0;
        rdata     = '0;
        load_reg  = 1'b0;
        dump_reg  = 1'b0;
        reg_num   = '0;
        reg_wdata = '0;
        case (state)
            IDLE: begin
                state_nx = grant ? ACCESS : IDLE;
            end
            ACCESS: begin
                state_nx = RESP;
                gnt0     = !owner;
                gnt1     = owner;
                reg_num  = h_num;
                if (h_we) begin
                    load_reg  = 1'b1;
                    reg_wdata = h_wdata;
                end else begin
                    dump_reg  = 1'b1;
                end
            end
            RESP: begin
                state_nx = IDLE;
                gnt0     = !owner;
                gnt1     = owner;
                ack0     = !owner;
                ack1     = owner;
                rdata    = h_we ? '0 : bus.RegRData;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.gnt0      = gnt0;
    assign bus.gnt1      = gnt1;
    assign bus.ack0      = ack0;
    assign bus.ack1      = ack1;
    assign bus.rdata     = rdata;
    assign bus.LoadReg   = load_reg;
    assign bus.DumpReg   = dump_reg;
    assign bus.RegNumber = reg_num;
    assign bus.RegWData  = reg_wdata;
endmodule

// File: tb/tb_reg_arbiter.sv
// Directed bench for reg_arbiter with a small register-file memory attached.
// Expectations follow ARB_ROUND_ROBIN_EN when it is defined for the build.
module tb_reg_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;

    logic [7:0] mem [16];
    logic [7:0] rrd = 8'h00;

    reg_arbiter_if #(.DATA_W(8), .REGN_W(4)) bus ();

    reg_arbiter #(.DATA_W(8), .REGN_W(4)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.LoadReg) mem[bus.RegNumber] <= bus.RegWData;
        if (bus.DumpReg) rrd <= mem[bus.RegNumber];
    end

    assign bus.RegRData = rrd;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    function automatic logic [5:0] strobes();
        return {bus.gnt0, bus.gnt1, bus.ack0, bus.ack1,
                bus.LoadReg, bus.DumpReg};
    endfunction

    logic [1:0]  aseq;
    int          na;
    logic [17:0] gseq;
    int          ng;
    int          first0;
    int          n0;
    logic        hits;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
        bus.lock0 = 0; bus.lock1 = 0; bus.num0 = 0; bus.num1 = 0;
        bus.wdata0 = 0; bus.wdata1 = 0;
        do_reset();

        chk("rst_strobes", 32'(strobes()), 0);
        chk("rst_regnum", 32'(bus.RegNumber), 0);
        chk("rst_wdata", 32'(bus.RegWData), 0);
        chk("rst_rdata", 32'(bus.rdata), 0);

        // port 0 write A5 -> reg 3, then read back
        bus.req0 = 1; bus.we0 = 1; bus.num0 = 4'd3; bus.wdata0 = 8'hA5;
        tick();
        bus.num0 = 4'd9; bus.wdata0 = 8'h11;
        chk("wr_strobes", 32'(strobes()), 32'b10_00_10);
        chk("wr_regnum", 32'(bus.RegNumber), 3);
        chk("wr_wdata", 32'(bus.RegWData), 32'hA5);
        tick();
        chk("wr_ack", 32'(strobes()), 32'b10_10_00);
        chk("wr_rdata", 32'(bus.rdata), 0);
        bus.we0 = 0; bus.num0 = 4'd3;
        tick();
        chk("idle_gap", 32'(strobes()), 0);
        tick();
        chk("rd_strobes", 32'(strobes()), 32'b10_00_01);
        chk("rd_regnum", 32'(bus.RegNumber), 3);
        tick();
        chk("rd_ack", 32'(strobes()), 32'b10_10_00);
        chk("rd_rdata", 32'(bus.rdata), 32'hA5);
        bus.req0 = 0;
        tick();
        chk("rd_done", 32'(strobes()), 0);

        // simultaneous reads from both ports
        do_reset();
        bus.req0 = 1; bus.req1 = 1; bus.we0 = 0; bus.we1 = 0;
        bus.num0 = 4'd3; bus.num1 = 4'd3;
        aseq = 2'b11; na = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.ack0 || bus.ack1) begin
                if (na < 2) aseq[na] = bus.ack1;
                na++;
            end
        end
        bus.req0 = 0; bus.req1 = 0;
        chk("both_nack", 32'(na), 2);
`ifdef ARB_ROUND_ROBIN_EN
        chk("both_order", 32'(aseq), 32'b10);
`else
        chk("both_order", 32'(aseq), 32'b00);
`endif
        tick();

        // port 1 locked while port 0 waits: 15 grants, one to port 0, resume
        do_reset();
        bus.req1 = 1; bus.lock1 = 1; bus.we1 = 0; bus.num1 = 4'd3;
        bus.we0 = 0; bus.num0 = 4'd3;
        gseq = '0; ng = 0;
        for (int i = 0; i < 54; i++) begin
            tick();
            if (bus.DumpReg) begin
                if (ng < 18) gseq[ng] = bus.gnt1;
                ng++;
            end
            if (bus.ack0) bus.req0 = 0;
            if (i == 0) bus.req0 = 1;
        end
        first0 = -1; n0 = 0;
        for (int i = 0; i < 18; i++) begin
            if (!gseq[i]) begin
                n0++;
                if (first0 < 0) first0 = i;
            end
        end
        chk("lock_ngrant", 32'(ng), 18);
        chk("lock_first0", 32'(first0), 15);
        chk("lock_n0", 32'(n0), 1);
        chk("lock_seq", 32'(gseq), 32'h37FFF);
        bus.req1 = 0; bus.lock1 = 0; bus.req0 = 0;
        tick();
        tick();

        // reset during ACCESS of a port 1 write
        do_reset();
        bus.req1 = 1; bus.we1 = 1; bus.num1 = 4'd5; bus.wdata1 = 8'h3C;
        tick();
        chk("abort_access", 32'(strobes()), 32'b01_00_10);
        reset = 1; bus.req1 = 0;
        tick();
        chk("abort_strobes", 32'(strobes()), 0);
        chk("abort_regnum", 32'(bus.RegNumber), 0);
        chk("abort_wdata", 32'(bus.RegWData), 0);
        reset = 0;
        tick();
        chk("abort_noack", 32'(strobes()), 0);

        // req1 pulse during RESP of a port 0 read is ignored
        bus.req0 = 1; bus.we0 = 0; bus.num0 = 4'd3;
        tick();
        chk("pulse_access", 32'(strobes()), 32'b10_00_01);
        tick();
        chk("pulse_ack0", 32'(strobes()), 32'b10_10_00);
        chk("pulse_rdata", 32'(bus.rdata), 32'hA5);
        bus.req0 = 0; bus.req1 = 1; bus.we1 = 0;
        tick();
        bus.req1 = 0;
        hits = 0;
        for (int i = 0; i < 4; i++) begin
            hits |= bus.gnt1 | bus.ack1;
            tick();
        end
        chk("pulse_ignored", 32'(hits), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
